// File: rtl/candy_alu_seq_pkg.sv
// Shared opcodes, flag positions, reset polarity and FSM state type for the
// sequential execute-stage ALU.
package candy_alu_seq_pkg;

    localparam int ALUOP_W = 8;

    localparam logic RST_ENABLE  = 1'b1;
    localparam logic RST_DISABLE = 1'b0;

    localparam logic [ALUOP_W-1:0] EXE_ADD = 8'h01;
    localparam logic [ALUOP_W-1:0] EXE_SUB = 8'h02;
    localparam logic [ALUOP_W-1:0] EXE_NEG = 8'h03;
    localparam logic [ALUOP_W-1:0] EXE_AND = 8'h04;
    localparam logic [ALUOP_W-1:0] EXE_OR  = 8'h05;
    localparam logic [ALUOP_W-1:0] EXE_XOR = 8'h06;
    localparam logic [ALUOP_W-1:0] EXE_NOT = 8'h07;
    localparam logic [ALUOP_W-1:0] EXE_SLL = 8'h08;
    localparam logic [ALUOP_W-1:0] EXE_SRL = 8'h09;
    localparam logic [ALUOP_W-1:0] EXE_SRA = 8'h0A;
    localparam logic [ALUOP_W-1:0] EXE_MUL = 8'h0B;

    // Bit positions inside flags_o = {N, Z, C, V}.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/candy_alu_seq_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// done_o is asserted during the cycle whose closing edge performs the last
// iteration; product_o then already carries the final product so the caller
// can capture it on that same edge.
module candy_mul_seq
    import candy_alu_seq_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;

    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == LAST_ITER);
    assign product_o = acc_d;

    // Load operands on start, then add/shift once per cycle until WIDTH bits are consumed.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/candy_alu_seq.sv
// Execute-stage ALU with valid/ready handshakes on both sides. Single-cycle
// ops land in the output slot on the accept edge; MUL is handed to the
// iterative multiplier and the slot is written when it finishes.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | slot empty or holding a result; may accept
// MUL     | multiplier iterating; upstream stalled
module candy_alu_seq
    import candy_alu_seq_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [WIDTH-1:0]   reg1_i,
    input  logic [WIDTH-1:0]   reg2_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   res_o,
    output logic [3:0]         flags_o
);

    localparam logic [SHW:0]     WIDTH_SH = (SHW + 1)'(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

    state_e state_q, state_d;

    logic               valid_q;
    logic [WIDTH-1:0]   res_q;
    logic [3:0]         flags_q;

    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH-1:0]   neg_w;
    logic [SHW-1:0]     sh_amt;
    logic               sh_over;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [3:0]         alu_flags;
    logic [3:0]         mul_flags;
    logic               load_alu;
    logic               load_mul;

    candy_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (reg1_i),
        .b_i       (reg2_i),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    assign add_w   = {1'b0, reg1_i} + {1'b0, reg2_i};
    assign sub_w   = {1'b0, reg1_i} - {1'b0, reg2_i};
    assign neg_w   = '0 - reg1_i;
    assign sh_amt  = reg2_i[SHW-1:0];
    assign sh_over = ({1'b0, sh_amt} >= WIDTH_SH);

    // Single-cycle datapath: result plus carry/borrow and signed-overflow.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (aluop_i)
            EXE_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (reg1_i[WIDTH-1] == reg2_i[WIDTH-1]) &&
                          (add_w[WIDTH-1] != reg1_i[WIDTH-1]);
            end
            EXE_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (reg1_i[WIDTH-1] != reg2_i[WIDTH-1]) &&
                          (sub_w[WIDTH-1] != reg1_i[WIDTH-1]);
            end
            EXE_NEG: begin
                alu_res = neg_w;
                alu_c   = (reg1_i != '0);
                alu_v   = (reg1_i == MOST_NEG);
            end
            EXE_AND: alu_res = reg1_i & reg2_i;
            EXE_OR:  alu_res = reg1_i | reg2_i;
            EXE_XOR: alu_res = reg1_i ^ reg2_i;
            EXE_NOT: alu_res = ~reg1_i;
            EXE_SLL: alu_res = sh_over ? '0 : (reg1_i << sh_amt);
            EXE_SRL: alu_res = sh_over ? '0 : (reg1_i >> sh_amt);
            EXE_SRA: alu_res = sh_over ? {WIDTH{reg1_i[WIDTH-1]}}
                                       : WIDTH'($signed(reg1_i) >>> sh_amt);
            default: alu_res = '0;
        endcase
    end

    assign alu_flags = pack_flags(alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v);
    assign mul_flags = pack_flags(mul_product[WIDTH-1],
                                  (mul_product[WIDTH-1:0] == '0),
                                  1'b0,
                                  (mul_product[2*WIDTH-1:WIDTH] != '0));

    // Next-state and handshake decode; ready_o depends only on state and the slot.
    always_comb begin
        state_d   = state_q;
        ready_o   = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_o = !valid_q || ready_i;
                if (valid_i && ready_o && (aluop_i == EXE_MUL)) begin
                    mul_start = 1'b1;
                    state_d   = ST_MUL;
                end
            end
            ST_MUL: begin
                // Falling out on !mul_busy keeps the FSM from wedging if the
                // engine ever stops without signalling done.
                if (mul_done || !mul_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign load_alu = valid_i && ready_o && (aluop_i != EXE_MUL);
    assign load_mul = (state_q == ST_MUL) && mul_done;

    // State register.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output slot: a new result may load on the same edge the old one is consumed.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else if (load_alu) begin
            valid_q <= 1'b1;
            res_q   <= alu_res;
            flags_q <= alu_flags;
        end else if (load_mul) begin
            valid_q <= 1'b1;
            res_q   <= mul_product[WIDTH-1:0];
            flags_q <= mul_flags;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign res_o   = res_q;
    assign flags_o = flags_q;

endmodule

// File: tb/tb_candy_alu_seq.sv
// Bench for candy_alu_seq at WIDTH=24: directed vectors plus a randomized run
// against an arithmetic reference model and a result queue.
module tb_candy_alu_seq;
    import candy_alu_seq_pkg::*;

    localparam int W   = 24;
    localparam int SHW = $clog2(W);

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_i;
    logic               ready_o;
    logic [ALUOP_W-1:0] aluop_i;
    logic [W-1:0]       reg1_i;
    logic [W-1:0]       reg2_i;
    logic               valid_o;
    logic               ready_i;
    logic [W-1:0]       res_o;
    logic [3:0]         flags_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    candy_alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .aluop_i (aluop_i),
        .reg1_i  (reg1_i),
        .reg2_i  (reg2_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .res_o   (res_o),
        .flags_o (flags_o)
    );

    // Reference: integer arithmetic on the operands' numeric values; returns {N,Z,C,V,res}.
    function automatic logic [W+3:0] ref_model(input logic [7:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint ua, ub, sa, sb, lim, half, r, s;
        int     amt;
        logic   c, v;
        logic [W-1:0] res;
        lim  = longint'(1) << W;
        half = longint'(1) << (W - 1);
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = (ua >= half) ? ua - lim : ua;
        sb   = (ub >= half) ? ub - lim : ub;
        amt  = int'(ub % (longint'(1) << SHW));
        c    = 1'b0;
        v    = 1'b0;
        r    = 0;
        case (op)
            EXE_ADD: begin r = ua + ub; c = (r >= lim); s = sa + sb; v = (s >= half) || (s < -half); end
            EXE_SUB: begin r = ua - ub; c = (ua < ub);  s = sa - sb; v = (s >= half) || (s < -half); end
            EXE_NEG: begin r = -ua; c = (ua != 0); v = (-sa >= half); end
            EXE_AND: r = ua & ub;
            EXE_OR:  r = ua | ub;
            EXE_XOR: r = ua ^ ub;
            EXE_NOT: r = ~ua;
            EXE_SLL: r = (amt >= W) ? 0 : (ua << amt);
            EXE_SRL: r = (amt >= W) ? 0 : (ua >> amt);
            EXE_SRA: r = sa >>> amt;
            EXE_MUL: begin r = ua * ub; v = (r >= lim); end
            default: r = 0;
        endcase
        r   = r & (lim - 1);
        res = r[W-1:0];
        return {res[W-1], (res == '0), c, v, res};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 24'h000000;
            1:       return 24'h800000;
            2:       return 24'h7fffff;
            3:       return 24'hffffff;
            4:       return W'($urandom_range(0, 40));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        // An offered op on the reset edge must be ignored.
        @(negedge clk);
        rst = 1'b1; valid_i = 1'b1; aluop_i = EXE_ADD; reg1_i = 24'h5; reg2_i = 24'h6; ready_i = 1'b1;
        @(negedge clk);
        rst = 1'b0; valid_i = 1'b0;
        #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        total++; if (res_o !== '0) begin bad++; $display("FAIL reset_res got=%h want=000000", res_o); end
        total++; if (flags_o !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", flags_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_o); end
    endtask

    // Back-to-back single-cycle ops, one per cycle with ready_i high.
    task automatic test_single_ops();
        localparam int N = 19;
        logic [7:0]   ops [N] = '{EXE_ADD, EXE_ADD, EXE_SUB, EXE_AND, EXE_NOT, EXE_SLL, EXE_SRL,
                                  EXE_SRA, EXE_SRL, EXE_NEG, EXE_NEG, EXE_SRA, EXE_SUB, 8'hff,
                                  EXE_XOR, EXE_OR, EXE_SLL, EXE_ADD, EXE_SUB};
        logic [W-1:0] a [N] = '{24'h9bcdef, 24'h7fffff, 24'h9bcdef, 24'h9bcdef, 24'h9bcdef,
                                24'h9bcdef, 24'h9bcdef, 24'h9bcdef, 24'h9bcdef, 24'h800000,
                                24'h000000, 24'h9bcdef, 24'h000000, 24'h123456, 24'h9bcdef,
                                24'h9bcdef, 24'h9bcdef, 24'hffffff, 24'h800000};
        logic [W-1:0] b [N] = '{24'h123456, 24'h000001, 24'h123456, 24'h123456, 24'h000000,
                                24'h000016, 24'h000016, 24'h000016, 24'h00001f, 24'h000000,
                                24'h000000, 24'h00001f, 24'h000001, 24'h654321, 24'h123456,
                                24'h123456, 24'h000020, 24'h000001, 24'h000001};
        logic [W-1:0] er [N] = '{24'hae0245, 24'h800000, 24'h899999, 24'h120446, 24'h643210,
                                 24'hc00000, 24'h000002, 24'hfffffe, 24'h000000, 24'h800000,
                                 24'h000000, 24'hffffff, 24'hffffff, 24'h000000, 24'h89f9b9,
                                 24'h9bfdff, 24'h9bcdef, 24'h000000, 24'h7fffff};
        logic [3:0]   ef [N] = '{4'b1000, 4'b1001, 4'b1000, 4'b0000, 4'b0000,
                                 4'b1000, 4'b0000, 4'b1000, 4'b0100, 4'b1011,
                                 4'b0100, 4'b1000, 4'b1010, 4'b0100, 4'b1000,
                                 4'b1000, 4'b1000, 4'b0110, 4'b0001};
        ready_i = 1'b1;
        for (int i = 0; i <= N; i++) begin
            @(negedge clk);
            if (i < N) begin
                valid_i = 1'b1; aluop_i = ops[i]; reg1_i = a[i]; reg2_i = b[i];
            end else begin
                valid_i = 1'b0;
            end
            #1;
            if (i > 0) begin
                total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL op%0d_valid got=%b want=1", i-1, valid_o); end
                total++; if (res_o !== er[i-1]) begin bad++; $display("FAIL op%0d_res got=%h want=%h", i-1, res_o, er[i-1]); end
                total++; if (flags_o !== ef[i-1]) begin bad++; $display("FAIL op%0d_flags got=%b want=%b", i-1, flags_o, ef[i-1]); end
            end
            if (i < N) begin
                total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL op%0d_ready got=%b want=1", i, ready_o); end
            end
        end
        @(negedge clk); #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", valid_o); end
    endtask

    task automatic test_mul();
        logic [W-1:0] ma [2] = '{24'd113, 24'h800000};
        logic [W-1:0] mb [2] = '{24'd32345, 24'h000002};
        logic [W-1:0] er [2] = '{24'h37c549, 24'h000000};
        logic [3:0]   ef [2] = '{4'b0000, 4'b0101};
        int waitc, lowc;
        ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            valid_i = 1'b1; aluop_i = EXE_MUL; reg1_i = ma[k]; reg2_i = mb[k];
            #1;
            total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL mul%0d_accept_ready got=%b want=1", k, ready_o); end
            waitc = 0;
            lowc  = 0;
            while (waitc < 60) begin
                @(negedge clk);
                valid_i = 1'b0; aluop_i = EXE_ADD; reg1_i = W'($urandom); reg2_i = W'($urandom);
                #1;
                if (valid_o === 1'b1) break;
                if (ready_o === 1'b0) lowc++;
                waitc++;
            end
            total++; if (waitc != W) begin bad++; $display("FAIL mul%0d_latency got=%0d want=%0d", k, waitc, W); end
            total++; if (lowc != W) begin bad++; $display("FAIL mul%0d_ready_low got=%0d want=%0d", k, lowc, W); end
            total++; if (res_o !== er[k]) begin bad++; $display("FAIL mul%0d_res got=%h want=%h", k, res_o, er[k]); end
            total++; if (flags_o !== ef[k]) begin bad++; $display("FAIL mul%0d_flags got=%b want=%b", k, flags_o, ef[k]); end
            total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL mul%0d_ready_after got=%b want=1", k, ready_o); end
        end
        @(negedge clk); #1;
    endtask

    task automatic test_back_to_back_stall();
        @(negedge clk);
        ready_i = 1'b0; valid_i = 1'b1; aluop_i = EXE_ADD; reg1_i = 24'h1; reg2_i = 24'h2;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL bp_first_ready got=%b want=1", ready_o); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            valid_i = 1'b1; aluop_i = EXE_ADD; reg1_i = 24'h10; reg2_i = 24'h20;
            #1;
            total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL bp_hold_valid%0d got=%b want=1", k, valid_o); end
            total++; if (res_o !== 24'h3) begin bad++; $display("FAIL bp_hold_res%0d got=%h want=000003", k, res_o); end
            total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL bp_hold_ready%0d got=%b want=0", k, ready_o); end
        end
        @(negedge clk);
        ready_i = 1'b1;
        #1;
        total++; if (res_o !== 24'h3) begin bad++; $display("FAIL bp_release_res got=%h want=000003", res_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", ready_o); end
        @(negedge clk);
        aluop_i = EXE_ADD; reg1_i = 24'h100; reg2_i = 24'h200;
        #1;
        total++; if (res_o !== 24'h30) begin bad++; $display("FAIL bp_second_res got=%h want=000030", res_o); end
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        total++; if (res_o !== 24'h300 || valid_o !== 1'b1) begin bad++; $display("FAIL bp_third_res got=%h/%b want=000300/1", res_o, valid_o); end
        @(negedge clk); #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b want=0", valid_o); end
    endtask

    task automatic test_reset_mid_mul();
        int stray;
        ready_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b1; aluop_i = EXE_MUL; reg1_i = 24'hffffff; reg2_i = 24'hffffff;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rmul_valid got=%b want=0", valid_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rmul_ready got=%b want=1", ready_o); end
        stray = 0;
        repeat (30) begin
            @(negedge clk); #1;
            if (valid_o !== 1'b0 || ready_o !== 1'b1) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL rmul_quiet got=%0d want=0 bad cycles", stray); end
        @(negedge clk);
        valid_i = 1'b1; aluop_i = EXE_ADD; reg1_i = 24'h1; reg2_i = 24'h1;
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        total++; if (valid_o !== 1'b1 || res_o !== 24'h2 || flags_o !== 4'b0) begin
            bad++; $display("FAIL rmul_add got=%b/%h/%b want=1/000002/0000", valid_o, res_o, flags_o);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_random();
        logic [W+3:0] q[$];
        logic [W+3:0] mul_exp;
        logic [W+3:0] got, want;
        logic [7:0]   opset [12] = '{EXE_ADD, EXE_SUB, EXE_NEG, EXE_AND, EXE_OR, EXE_XOR,
                                     EXE_NOT, EXE_SLL, EXE_SRL, EXE_SRA, EXE_MUL, 8'hc3};
        logic exp_ready;
        int mul_cnt = 0;
        do_reset();
        for (int cyc = 0; cyc < 1400; cyc++) begin
            @(negedge clk);
            if (cyc < 1300) begin
                valid_i = ($urandom_range(0, 9) < 7);
                ready_i = ($urandom_range(0, 3) != 0);
            end else begin
                valid_i = 1'b0;
                ready_i = 1'b1;
            end
            aluop_i = opset[$urandom_range(0, 11)];
            reg1_i  = pick_operand();
            reg2_i  = pick_operand();
            #1;
            total++; if (valid_o !== (q.size() != 0)) begin
                bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, valid_o, (q.size() != 0));
            end
            exp_ready = (mul_cnt == 0) && ((q.size() == 0) || ready_i);
            total++; if (ready_o !== exp_ready) begin
                bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, ready_o, exp_ready);
            end
            if (valid_o === 1'b1 && ready_i) begin
                got = {flags_o, res_o};
                if (q.size() == 0) begin
                    total++; bad++; $display("FAIL rnd_unexpected cyc=%0d got=%h want=none", cyc, got);
                end else begin
                    want = q.pop_front();
                    total++; if (got !== want) begin
                        bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", cyc, got, want);
                    end
                end
            end
            if (mul_cnt > 0) begin
                mul_cnt--;
                if (mul_cnt == 0) q.push_back(mul_exp);
            end
            if (valid_i && ready_o === 1'b1) begin
                if (aluop_i == EXE_MUL) begin
                    mul_exp = ref_model(aluop_i, reg1_i, reg2_i);
                    mul_cnt = W;
                end else begin
                    q.push_back(ref_model(aluop_i, reg1_i, reg2_i));
                end
            end
        end
        total++; if (q.size() != 0 || mul_cnt != 0) begin
            bad++; $display("FAIL rnd_leftover got=%0d/%0d want=0/0", q.size(), mul_cnt);
        end
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        aluop_i = '0;
        reg1_i  = '0;
        reg2_i  = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_ops();
        test_mul();
        test_back_to_back_stall();
        test_reset_mid_mul();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
